// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller and the
// pipeline registers it steers.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    ERR_DRAIN = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // MEM-control bit positions inside the ID_EX / EXE_MEM control fields
  localparam int MEM_READ_BIT  = 0;
  localparam int MEM_WRITE_BIT = 1;
  localparam int BRANCH_BIT    = 2;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational hazard terms: load-use in ID/EX, taken branch at EXE_MEM,
// and an outstanding data-memory access.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rt,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rt,
  input  logic       i_mem_branch,
  input  logic       i_mem_zero,
  input  logic       i_mem_access,
  input  logic       i_dmem_ready,
  output logic       o_lu,
  output logic       o_taken,
  output logic       o_memwait
);

  logic w_rs_hit;
  logic w_rt_hit;

  // A load into $0 never produces a value, so it cannot create a hazard
  assign w_rs_hit  = (i_ex_rt == i_id_rs);
  assign w_rt_hit  = i_id_uses_rt & (i_ex_rt == i_id_rt);
  assign o_lu      = i_ex_mem_read & (i_ex_rt != REG_ZERO) & (w_rs_hit | w_rt_hit);
  assign o_taken   = i_mem_branch & i_mem_zero;
  assign o_memwait = i_mem_access & ~i_dmem_ready;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: output muxing,
// memory-wait FSM with timeout, and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
  output logic             back_hold,
  output logic             pc_src_branch,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_err
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_stall;
  logic              r_err;

  logic w_lu;
  logic w_taken;
  logic w_memwait;

  hazard_detect u_hazard_detect (
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .i_id_uses_rt  (id_uses_rt),
    .i_ex_mem_read (ex_mem_read),
    .i_ex_rt       (ex_rt),
    .i_mem_branch  (mem_branch),
    .i_mem_zero    (mem_zero),
    .i_mem_access  (mem_access),
    .i_dmem_ready  (dmem_ready),
    .o_lu          (w_lu),
    .o_taken       (w_taken),
    .o_memwait     (w_memwait)
  );

  // Priority: drain > memory wait > taken branch > load-use
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_flush  = 1'b0;
    back_hold     = 1'b0;
    pc_src_branch = 1'b0;
    if (!reset) begin
      if (r_state == ERR_DRAIN) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end else if (w_memwait) begin
        back_hold   = 1'b1;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end else if (w_taken) begin
        pc_src_branch = 1'b1;
        if_id_flush   = 1'b1;
        id_ex_bubble  = 1'b1;
        ex_mem_flush  = 1'b1;
      end else if (w_lu) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RUN;
      r_wait  <= '0;
      r_stall <= '0;
      r_err   <= 1'b0;
    end else begin
      if (!pc_write && (r_stall != '1)) r_stall <= r_stall + CNT_W'(1);
      case (r_state)
        RUN: begin
          if (w_memwait) begin
            r_state <= MEM_WAIT;
            r_wait  <= '0;
          end
        end
        MEM_WAIT: begin
          if (!w_memwait) begin
            r_state <= RUN;
            r_wait  <= '0;
          end else if (r_wait == WAIT_LAST) begin
            r_state <= ERR_DRAIN;
            r_err   <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        ERR_DRAIN: begin
          r_state <= RUN;
          r_wait  <= '0;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign state        = r_state;
  assign stall_cycles = r_stall;
  assign mem_err      = r_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench: the driver queues hand-computed expectations,
// a negedge monitor pops and compares against the DUT every cycle.
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0;
  logic       mem_branch = 1'b0, mem_zero = 1'b0, mem_access = 1'b0, dmem_ready = 1'b0;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, back_hold, pc_src_branch;
  logic [1:0] state;
  logic [3:0] stall_cycles;
  logic       mem_err;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_flush(ex_mem_flush), .back_hold(back_hold),
    .pc_src_branch(pc_src_branch), .state(state), .stall_cycles(stall_cycles),
    .mem_err(mem_err)
  );

  // ctl = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, back_hold, pc_src_branch}
  localparam logic [6:0] NORM  = 7'b1100000;
  localparam logic [6:0] LU    = 7'b0001000;
  localparam logic [6:0] TAKEN = 7'b1111101;
  localparam logic [6:0] HOLD  = 7'b0000010;
  localparam logic [6:0] DRAIN = 7'b0000000;

  typedef struct packed {
    logic [6:0] ctl;
    logic [1:0] st;
    logic [3:0] cnt;
    logic       err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  task automatic step(input string nm, input logic rst,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic emr, input logic [4:0] ert,
                      input logic br, input logic z, input logic acc, input logic rdy,
                      input logic [6:0] ctl, input logic [1:0] st, input logic [3:0] cnt,
                      input logic err);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_mem_read = emr; ex_rt = ert; mem_branch = br; mem_zero = z;
    mem_access = acc; dmem_ready = rdy;
    e.ctl = ctl; e.st = st; e.cnt = cnt; e.err = err;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are valid every cycle, so one expectation per negedge
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a.ctl = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, back_hold, pc_src_branch};
        a.st  = state;
        a.cnt = stall_cycles;
        a.err = mem_err;
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got ctl=%b st=%0d cnt=%0d err=%b, want ctl=%b st=%0d cnt=%0d err=%b",
                      nm, a.ctl, a.st, a.cnt, a.err, e.ctl, e.st, e.cnt, e.err);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    //   name        rst rs  rt  urt emr ert br z acc rdy  ctl    st cnt err
    step("rst_hold",  1, 8,  0,  0,  1,  8, 0, 0, 0, 0,   NORM,  0, 0,  0);
    step("lu_rs",     0, 8,  0,  0,  1,  8, 0, 0, 0, 0,   LU,    0, 0,  0);
    step("after_lu",  0, 1,  2,  1,  0,  0, 0, 0, 0, 0,   NORM,  0, 1,  0);
    step("load_r0",   0, 0,  0,  1,  1,  0, 0, 0, 0, 0,   NORM,  0, 1,  0);
    step("rt_unused", 0, 3,  9,  0,  1,  9, 0, 0, 0, 0,   NORM,  0, 1,  0);
    step("lu_rt",     0, 3,  9,  1,  1,  9, 0, 0, 0, 0,   LU,    0, 1,  0);
    step("taken_lu",  0, 8,  0,  0,  1,  8, 1, 1, 0, 0,   TAKEN, 0, 2,  0);
    step("not_taken", 0, 0,  0,  0,  0,  0, 1, 0, 0, 1,   NORM,  0, 2,  0);
    // memory wait with a taken branch pending behind it
    step("mw_enter",  0, 0,  0,  0,  0,  0, 1, 1, 1, 0,   HOLD,  0, 2,  0);
    step("mw_1",      0, 0,  0,  0,  0,  0, 1, 1, 1, 0,   HOLD,  1, 3,  0);
    step("mw_2",      0, 0,  0,  0,  0,  0, 1, 1, 1, 0,   HOLD,  1, 4,  0);
    step("mw_ready",  0, 0,  0,  0,  0,  0, 1, 1, 1, 1,   TAKEN, 1, 5,  0);
    step("mw_done",   0, 0,  0,  0,  0,  0, 0, 0, 0, 0,   NORM,  0, 5,  0);
    // timeout: four MEM_WAIT cycles, then one drain cycle
    step("to_enter",  0, 0,  0,  0,  0,  0, 0, 0, 1, 0,   HOLD,  0, 5,  0);
    step("to_w0",     0, 0,  0,  0,  0,  0, 0, 0, 1, 0,   HOLD,  1, 6,  0);
    step("to_w1",     0, 0,  0,  0,  0,  0, 0, 0, 1, 0,   HOLD,  1, 7,  0);
    step("to_w2",     0, 0,  0,  0,  0,  0, 0, 0, 1, 0,   HOLD,  1, 8,  0);
    step("to_w3",     0, 0,  0,  0,  0,  0, 0, 0, 1, 0,   HOLD,  1, 9,  0);
    step("to_drain",  0, 8,  0,  0,  1,  8, 1, 1, 1, 0,   DRAIN, 2, 10, 1);
    step("to_run",    0, 0,  0,  0,  0,  0, 0, 0, 0, 0,   NORM,  0, 11, 1);
    step("err_stick", 0, 0,  0,  0,  0,  0, 0, 0, 0, 0,   NORM,  0, 11, 1);
    // reset in the middle of a wait
    step("rw_enter",  0, 0,  0,  0,  0,  0, 0, 0, 1, 0,   HOLD,  0, 11, 1);
    step("rw_wait",   0, 0,  0,  0,  0,  0, 0, 0, 1, 0,   HOLD,  1, 12, 1);
    step("rw_reset",  1, 0,  0,  0,  0,  0, 0, 0, 1, 0,   NORM,  1, 13, 1);
    step("rw_after",  0, 0,  0,  0,  0,  0, 0, 0, 0, 0,   NORM,  0, 0,  0);
    // 20 load-use stalls saturate the 4-bit counter at 15
    for (int i = 0; i < 20; i++)
      step("sat",     0, 8,  0,  0,  1,  8, 0, 0, 0, 0,   LU,    0, 4'((i > 15) ? 15 : i), 0);
    step("sat_end",   0, 0,  0,  0,  0,  0, 0, 0, 0, 0,   NORM,  0, 15, 0);

    repeat (3) @(posedge clock);
    #1;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
